sram_frame_reader: RTL

- Read side of the SRAM frame buffer that the painting/writer block fills.
- Walks the buffer in raster order, fetching two 16-bit words per pixel, and reassembles them into 30-bit RGB.
- Buffers pixels in a small FIFO and hands them to the VGA timing block one pixel per request.
- Yields the SRAM bus whenever the writer holds it.

---
 rtl/sram_frame_reader_if.sv | 10 +
 rtl/sram_frame_reader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_reader_if.sv
// SRAM read bus between the frame reader (master) and the asynchronous SRAM (slave).
// Data is combinational from the address while oe_n is low.
interface sram_frame_reader_if;
   logic        oe_n;
   logic [19:0] addr;
   logic [15:0] dq;

   modport master (output oe_n, output addr, input dq);
   modport slave  (input oe_n, input addr, output dq);
endinterface

// File: rtl/sram_frame_reader.sv
// Raster-order SRAM reader: two 16-bit words per pixel are reassembled into 30-bit RGB,
// buffered in a small FIFO and popped one pixel per VGA request.
module sram_frame_reader #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_frame_start,
   input  logic                i_hold,
   input  logic                i_pix_req,
   sram_frame_reader_if.master io_sram,
   output logic [9:0]          o_r,
   output logic [9:0]          o_g,
   output logic [9:0]          o_b,
   output logic                o_underflow,
   output logic                o_frame_done
);
   localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int A_W = $clog2(FIFO_DEPTH);
   localparam int C_W = A_W + 1;
   localparam logic [C_W-1:0] DEPTH_C  = C_W'(FIFO_DEPTH);
   localparam logic [X_W-1:0] X_LAST   = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_ACTIVE - 1);

   typedef enum logic [1:0] {IDLE, RD_LO, RD_HI} state_t;

   state_t         r_state, w_state_nxt;
   logic           r_oe_n, w_oe_n_nxt;
   logic [19:0]    r_addr, w_addr_nxt;
   logic [X_W-1:0] r_x, w_x_nxt;
   logic [Y_W-1:0] r_y, w_y_nxt;
   logic           r_running;
   logic [14:0]    r_lo;
   logic [29:0]    r_mem [FIFO_DEPTH];
   logic [A_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [C_W-1:0] r_count, w_count_nxt;
   logic           w_push, w_pop, w_last, w_can_start, w_room_hi;
   logic [18:0]    w_idx, w_idx_nxt;
   logic [29:0]    w_pix;
   logic           w_unused_dq15;

   function automatic logic [18:0] pix_index(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return 19'(H_ACTIVE) * 19'(y) + 19'(x);
   endfunction

   assign io_sram.oe_n  = r_oe_n;
   assign io_sram.addr  = r_addr;
   assign w_unused_dq15 = io_sram.dq[15];

   assign w_idx       = pix_index(r_x, r_y);
   assign w_idx_nxt   = pix_index(w_x_nxt, w_y_nxt);
   assign w_last      = (r_x == X_LAST) && (r_y == Y_LAST);
   assign w_pop       = i_pix_req && (r_count != '0) && !i_frame_start;
   assign w_can_start = r_running && !i_hold && !o_frame_done && (r_count < DEPTH_C);
   // Room after this cycle's push: a same-cycle pop frees the slot the push takes.
   assign w_room_hi   = w_pop ? (r_count < DEPTH_C) : (r_count < DEPTH_C - C_W'(1));
   // R = lo[9:0], G = {lo[14:10], hi[14:10]}, B = hi[9:0]
   assign w_pix       = {r_lo[9:0], r_lo[14:10], io_sram.dq[14:10], io_sram.dq[9:0]};

   always_comb begin
      w_x_nxt = r_x + 1'b1;
      w_y_nxt = r_y;
      if (r_x == X_LAST) begin
         w_x_nxt = '0;
         w_y_nxt = r_y + 1'b1;
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + C_W'(1);
         2'b01:   w_count_nxt = r_count - C_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_oe_n_nxt  = 1'b1;
      w_addr_nxt  = r_addr;
      w_push      = 1'b0;
      if (i_frame_start) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_can_start) begin
                  w_state_nxt = RD_LO;
                  w_oe_n_nxt  = 1'b0;
                  w_addr_nxt  = {w_idx, 1'b0};
               end
            end
            RD_LO: begin
               if (i_hold) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = RD_HI;
                  w_oe_n_nxt  = 1'b0;
                  w_addr_nxt  = {w_idx, 1'b1};
               end
            end
            RD_HI: begin
               if (i_hold) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_push = 1'b1;
                  if (r_running && !w_last && w_room_hi) begin
                     w_state_nxt = RD_LO;
                     w_oe_n_nxt  = 1'b0;
                     w_addr_nxt  = {w_idx_nxt, 1'b0};
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_oe_n  <= 1'b1;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_oe_n  <= w_oe_n_nxt;
         r_addr  <= w_addr_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (r_state == RD_LO) r_lo <= io_sram.dq[14:0];
      if (w_push) r_mem[r_wr_ptr] <= w_pix;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x          <= '0;
         r_y          <= '0;
         r_running    <= 1'b0;
         o_frame_done <= 1'b0;
         o_underflow  <= 1'b0;
      end else if (i_frame_start) begin
         r_x          <= '0;
         r_y          <= '0;
         r_running    <= 1'b1;
         o_frame_done <= 1'b0;
         o_underflow  <= 1'b0;
      end else begin
         if (w_push) begin
            if (w_last) begin
               r_x          <= '0;
               r_y          <= '0;
               r_running    <= 1'b0;
               o_frame_done <= 1'b1;
            end else begin
               r_x <= w_x_nxt;
               r_y <= w_y_nxt;
            end
         end
         if (i_pix_req && (r_count == '0)) o_underflow <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_frame_start) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
      end
   end

   // A request on an empty FIFO outputs black; a frame start swallows the request.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         {o_r, o_g, o_b} <= '0;
      end else if (!i_frame_start && i_pix_req) begin
         if (r_count != '0) {o_r, o_g, o_b} <= r_mem[r_rd_ptr];
         else               {o_r, o_g, o_b} <= '0;
      end
   end
endmodule
